// File: rtl/apb_pkg.sv
// Shared types and defaults for the two-requester APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef logic req_id_t;

endpackage

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted requester
// and only moves when a grant is actually issued.
module apb_rr_arb
  import apb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output req_id_t    gnt_idx_o
);

  req_id_t last_q, last_d;

  always_comb begin
    gnt_o     = 2'b00;
    gnt_idx_o = 1'b0;
    last_d    = last_q;
    if (en_i && (req_i != 2'b00)) begin
      if (req_i == 2'b11) begin
        gnt_idx_o = ~last_q;
      end else begin
        gnt_idx_o = req_i[1];
      end
      gnt_o[gnt_idx_o] = 1'b1;
      last_d           = gnt_idx_o;
    end
  end

  // Reset value pretends requester 1 went last so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/apb_arb_master.sv
// APB master sharing one slave port between two local requesters, with
// round-robin arbitration, wait-state support and a PREADY watchdog.
module apb_arb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W
) (
  input  logic              pclk_i,
  input  logic              presetn_i,
  input  logic              req0_valid_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_rdata_o,
  output logic              rsp0_err_o,
  input  logic              req1_valid_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_rdata_o,
  output logic              rsp1_err_o,
  output logic              psel1_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e        state_q, state_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  req_id_t           owner_q, owner_d;

  logic              rsp0_valid_q, rsp1_valid_q;
  logic              rsp0_err_q, rsp1_err_q;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp1_rdata_q;

  logic              wd_hit;
  logic              xfer_done;
  logic              grant_win;
  logic [1:0]        gnt;
  req_id_t           gnt_idx;
  logic              granted;
  logic              rsp_err_c;
  logic [DATA_W-1:0] rsp_rdata_c;

  // Abort on the TIMEOUT-th ACCESS cycle without PREADY; PREADY in that cycle wins.
  always_comb begin
    wd_hit = 1'b0;
    if (TIMEOUT > 0) begin
      wd_hit = (state_q == ACCESS) && !pready_i && (32'(wd_cnt_q) == (TIMEOUT - 1));
    end
  end

  assign xfer_done = (state_q == ACCESS) && (pready_i || wd_hit);
  assign grant_win = (state_q == IDLE) || xfer_done;

  apb_rr_arb u_arb (
    .clk_i     (pclk_i),
    .rst_ni    (presetn_i),
    .en_i      (grant_win),
    .req_i     ({req1_valid_i, req0_valid_i}),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign granted      = gnt[0] | gnt[1];
  assign req0_ready_o = gnt[0];
  assign req1_ready_o = gnt[1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (granted) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = granted ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    owner_d  = owner_q;
    wd_cnt_d = wd_cnt_q;
    if (granted) begin
      paddr_d  = gnt_idx ? req1_addr_i  : req0_addr_i;
      pwdata_d = gnt_idx ? req1_wdata_i : req0_wdata_i;
      pwrite_d = gnt_idx ? req1_write_i : req0_write_i;
      owner_d  = gnt_idx;
      wd_cnt_d = '0;
    end else if ((TIMEOUT > 0) && (state_q == ACCESS) && !pready_i && !wd_hit) begin
      wd_cnt_d = wd_cnt_q + WD_W'(1);
    end
  end

  // A timeout reports as an error with no data; PSLVERR is only meaningful with PREADY.
  assign rsp_err_c   = pready_i ? pslverr_i : 1'b1;
  assign rsp_rdata_c = (pready_i && !pslverr_i && !pwrite_q) ? prdata_i : '0;

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q  <= IDLE;
      wd_cnt_q <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      owner_q  <= owner_d;
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      rsp0_valid_q <= 1'b0;
      rsp0_err_q   <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_err_q   <= 1'b0;
      rsp1_rdata_q <= '0;
    end else begin
      rsp0_valid_q <= xfer_done && !owner_q;
      rsp0_err_q   <= xfer_done && !owner_q && rsp_err_c;
      rsp0_rdata_q <= (xfer_done && !owner_q) ? rsp_rdata_c : '0;
      rsp1_valid_q <= xfer_done && owner_q;
      rsp1_err_q   <= xfer_done && owner_q && rsp_err_c;
      rsp1_rdata_q <= (xfer_done && owner_q) ? rsp_rdata_c : '0;
    end
  end

  assign psel1_o      = (state_q != IDLE);
  assign penable_o    = (state_q == ACCESS);
  assign pwrite_o     = pwrite_q;
  assign paddr_o      = paddr_q;
  assign pwdata_o     = pwdata_q;
  assign rsp0_valid_o = rsp0_valid_q;
  assign rsp0_err_o   = rsp0_err_q;
  assign rsp0_rdata_o = rsp0_rdata_q;
  assign rsp1_valid_o = rsp1_valid_q;
  assign rsp1_err_o   = rsp1_err_q;
  assign rsp1_rdata_o = rsp1_rdata_q;

endmodule

// File: tb/tb_apb_arb_master.sv
// Directed bench for apb_arb_master with a small memory-backed APB slave.
module tb_apb_arb_master;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        r0v = 1'b0, r0w = 1'b0, r1v = 1'b0, r1w = 1'b0;
  logic [31:0] r0a = '0, r0d = '0, r1a = '0, r1d = '0;
  logic        rdy0, rdy1, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic        psel1, penable, pwrite, pready, pslverr;
  logic [31:0] paddr, pwdata, prdata;

  int          vecs = 0;
  int          fails = 0;
  logic [31:0] mem [32];
  logic        written [32] = '{default: 1'b0};
  int          wait_n = 0;
  logic        hang = 1'b0;
  int          wcnt = 0;
  logic        in_range;

  always #5 pclk = ~pclk;

  apb_arb_master #(.TIMEOUT(4), .ADDR_W(32), .DATA_W(32)) dut (
    .pclk_i(pclk), .presetn_i(presetn),
    .req0_valid_i(r0v), .req0_write_i(r0w), .req0_addr_i(r0a), .req0_wdata_i(r0d),
    .req0_ready_o(rdy0), .rsp0_valid_o(rsp0_valid), .rsp0_rdata_o(rsp0_rdata), .rsp0_err_o(rsp0_err),
    .req1_valid_i(r1v), .req1_write_i(r1w), .req1_addr_i(r1a), .req1_wdata_i(r1d),
    .req1_ready_o(rdy1), .rsp1_valid_o(rsp1_valid), .rsp1_rdata_o(rsp1_rdata), .rsp1_err_o(rsp1_err),
    .psel1_o(psel1), .penable_o(penable), .pwrite_o(pwrite), .paddr_o(paddr), .pwdata_o(pwdata),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  // Slave: 32 words, errors on out-of-range or reading a never-written word.
  assign in_range = (paddr < 32);
  assign pready   = psel1 && penable && !hang && (wcnt >= wait_n);
  assign pslverr  = pready && (!in_range || (!pwrite && !written[paddr[4:0]]));
  assign prdata   = (in_range && written[paddr[4:0]]) ? mem[paddr[4:0]] : 32'hDEAD_BEEF;

  always @(posedge pclk) begin
    if (psel1 && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (pready && pwrite && !pslverr) begin
      mem[paddr[4:0]]     <= pwdata;
      written[paddr[4:0]] <= 1'b1;
    end
  end

  // Raise a request, wait (bounded) for its ready, drop it right after the accepting edge.
  task automatic issue(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge pclk);
    if (id == 0) begin r0v = 1'b1; r0w = wr; r0a = a; r0d = d; end
    else         begin r1v = 1'b1; r1w = wr; r1a = a; r1d = d; end
    #1;
    while (!((id == 0) ? rdy0 : rdy1) && n < 20) begin @(negedge pclk); #1; n++; end
    vecs++;
    if (n >= 20) begin fails++; $display("FAIL grant_wait: req%0d ready got 0 expected 1", id); end
    @(posedge pclk); #1;
    if (id == 0) r0v = 1'b0; else r1v = 1'b0;
  endtask

  task automatic test_reset;
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    vecs++; if ({psel1, penable, pwrite} !== 3'b000) begin fails++; $display("FAIL rst_ctrl: got %b expected 000", {psel1, penable, pwrite}); end
    vecs++; if ({paddr, pwdata} !== 64'h0) begin fails++; $display("FAIL rst_bus: got %h expected 0", {paddr, pwdata}); end
    vecs++; if ({rsp0_valid, rsp0_err, rsp1_valid, rsp1_err} !== 4'b0000) begin fails++; $display("FAIL rst_rsp: got %b expected 0000", {rsp0_valid, rsp0_err, rsp1_valid, rsp1_err}); end
    vecs++; if ({rsp0_rdata, rsp1_rdata} !== 64'h0) begin fails++; $display("FAIL rst_rdata: got %h expected 0", {rsp0_rdata, rsp1_rdata}); end
    presetn = 1'b1;
  endtask

  task automatic test_basic;
    issue(0, 1'b1, 32'd3, 32'hA5A5_0001);
    @(negedge pclk);
    vecs++; if ({psel1, penable} !== 2'b10) begin fails++; $display("FAIL wr_setup: got %b expected 10", {psel1, penable}); end
    vecs++; if ({pwrite, paddr, pwdata} !== {1'b1, 32'd3, 32'hA5A5_0001}) begin fails++; $display("FAIL wr_bus: got %h expected %h", {pwrite, paddr, pwdata}, {1'b1, 32'd3, 32'hA5A5_0001}); end
    @(negedge pclk);
    vecs++; if ({psel1, penable, rsp0_valid} !== 3'b110) begin fails++; $display("FAIL wr_access: got %b expected 110", {psel1, penable, rsp0_valid}); end
    @(negedge pclk);
    vecs++; if ({psel1, penable, rsp0_valid, rsp0_err, rsp1_valid} !== 5'b00100) begin fails++; $display("FAIL wr_rsp: got %b expected 00100", {psel1, penable, rsp0_valid, rsp0_err, rsp1_valid}); end
    vecs++; if (rsp0_rdata !== 32'h0) begin fails++; $display("FAIL wr_rdata: got %h expected 0", rsp0_rdata); end
    @(negedge pclk);
    vecs++; if (rsp0_valid !== 1'b0) begin fails++; $display("FAIL wr_pulse: got %b expected 0", rsp0_valid); end
    issue(0, 1'b0, 32'd3, 32'h0);
    repeat (3) @(negedge pclk);
    vecs++; if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b10, 32'hA5A5_0001}) begin fails++; $display("FAIL rd_data: got %h expected %h", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b10, 32'hA5A5_0001}); end
  endtask

  task automatic test_arb;
    presetn = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    r0v = 1'b1; r0w = 1'b1; r0a = 32'd1; r0d = 32'h11;
    r1v = 1'b1; r1w = 1'b1; r1a = 32'd2; r1d = 32'h22;
    #1;
    vecs++; if ({rdy1, rdy0} !== 2'b01) begin fails++; $display("FAIL tie_first: got %b expected 01", {rdy1, rdy0}); end
    @(posedge pclk); #1; r0v = 1'b0;
    @(negedge pclk);
    vecs++; if ({paddr, rdy1} !== {32'd1, 1'b0}) begin fails++; $display("FAIL tie_setup: got %h expected %h", {paddr, rdy1}, {32'd1, 1'b0}); end
    @(negedge pclk);
    vecs++; if (rdy1 !== 1'b1) begin fails++; $display("FAIL chain_ready: got %b expected 1", rdy1); end
    @(posedge pclk); #1; r1v = 1'b0;
    @(negedge pclk);
    vecs++; if ({psel1, penable, rsp0_valid, paddr} !== {3'b101, 32'd2}) begin fails++; $display("FAIL chain_setup: got %h expected %h", {psel1, penable, rsp0_valid, paddr}, {3'b101, 32'd2}); end
    repeat (2) @(negedge pclk);
    vecs++; if ({psel1, rsp1_valid, rsp0_valid} !== 3'b010) begin fails++; $display("FAIL chain_rsp: got %b expected 010", {psel1, rsp1_valid, rsp0_valid}); end
    issue(0, 1'b1, 32'd4, 32'h44);
    repeat (3) @(negedge pclk);
    @(negedge pclk);
    r0v = 1'b1; r0w = 1'b1; r0a = 32'd5; r0d = 32'h55;
    r1v = 1'b1; r1w = 1'b1; r1a = 32'd6; r1d = 32'h66;
    #1;
    vecs++; if ({rdy1, rdy0} !== 2'b10) begin fails++; $display("FAIL tie_rotate: got %b expected 10", {rdy1, rdy0}); end
    @(posedge pclk); #1; r1v = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    vecs++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL chain_ready2: got %b expected 1", rdy0); end
    @(posedge pclk); #1; r0v = 1'b0;
    @(negedge pclk);
    vecs++; if ({rsp1_valid, paddr} !== {1'b1, 32'd5}) begin fails++; $display("FAIL chain_setup2: got %h expected %h", {rsp1_valid, paddr}, {1'b1, 32'd5}); end
    repeat (2) @(negedge pclk);
    vecs++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin fails++; $display("FAIL chain_rsp2: got %b expected 10", {rsp0_valid, rsp1_valid}); end
  endtask

  task automatic test_wait_states;
    wait_n = 3;
    issue(1, 1'b1, 32'd5, 32'hCAFE_0005);
    @(negedge pclk);
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      vecs++; if ({penable, rsp1_valid, paddr, pwdata} !== {2'b10, 32'd5, 32'hCAFE_0005}) begin fails++; $display("FAIL wait_cycle%0d: got %h expected %h", k, {penable, rsp1_valid, paddr, pwdata}, {2'b10, 32'd5, 32'hCAFE_0005}); end
    end
    @(negedge pclk);
    vecs++; if ({psel1, penable, rsp1_valid, rsp1_err} !== 4'b0010) begin fails++; $display("FAIL wait_rsp: got %b expected 0010", {psel1, penable, rsp1_valid, rsp1_err}); end
    wait_n = 0;
  endtask

  task automatic test_timeout;
    hang = 1'b1;
    issue(0, 1'b0, 32'd3, 32'h0);
    @(negedge pclk);
    for (int k = 0; k < 4; k++) begin
      @(negedge pclk);
      vecs++; if ({psel1, penable, rsp0_valid} !== 3'b110) begin fails++; $display("FAIL to_cycle%0d: got %b expected 110", k, {psel1, penable, rsp0_valid}); end
    end
    @(negedge pclk);
    vecs++; if ({psel1, penable, rsp0_valid, rsp0_err} !== 4'b0011) begin fails++; $display("FAIL to_rsp: got %b expected 0011", {psel1, penable, rsp0_valid, rsp0_err}); end
    vecs++; if (rsp0_rdata !== 32'h0) begin fails++; $display("FAIL to_rdata: got %h expected 0", rsp0_rdata); end
    hang = 1'b0;
  endtask

  task automatic test_slave_err;
    issue(0, 1'b0, 32'd7, 32'h0);
    repeat (3) @(negedge pclk);
    vecs++; if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b11, 32'h0}) begin fails++; $display("FAIL err_rd: got %h expected %h", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b11, 32'h0}); end
    issue(1, 1'b1, 32'd40, 32'h1234);
    repeat (3) @(negedge pclk);
    vecs++; if ({rsp1_valid, rsp1_err, rsp0_valid} !== 3'b110) begin fails++; $display("FAIL err_wr: got %b expected 110", {rsp1_valid, rsp1_err, rsp0_valid}); end
  endtask

  task automatic test_reset_mid;
    wait_n = 3;
    issue(1, 1'b1, 32'd9, 32'h99);
    repeat (2) @(negedge pclk);
    #2 presetn = 1'b0;
    #1;
    vecs++; if ({psel1, penable} !== 2'b00) begin fails++; $display("FAIL rstmid_drop: got %b expected 00", {psel1, penable}); end
    @(negedge pclk);
    presetn = 1'b1;
    wait_n = 0;
    repeat (2) begin
      @(negedge pclk);
      vecs++; if ({rsp0_valid, rsp1_valid, psel1} !== 3'b000) begin fails++; $display("FAIL rstmid_norsp: got %b expected 000", {rsp0_valid, rsp1_valid, psel1}); end
    end
    issue(0, 1'b0, 32'd3, 32'h0);
    repeat (3) @(negedge pclk);
    vecs++; if ({rsp0_valid, rsp0_err, rsp0_rdata} !== {2'b10, 32'hA5A5_0001}) begin fails++; $display("FAIL rstmid_after: got %h expected %h", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b10, 32'hA5A5_0001}); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arb();
    test_wait_states();
    test_timeout();
    test_slave_err();
    test_reset_mid();
    repeat (2) @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/apb_arb_master.md
Name: apb_arb_master

Overview:
APB master that shares one APB slave port (e.g. the memory slave) between two local requesters. It arbitrates round-robin and drives the IDLE/SETUP/ACCESS protocol with PSEL1/PENABLE. It honours PREADY wait states and returns read data and PSLVERR to the granted requester. A watchdog aborts transfers whose PREADY never arrives.

Parameters:
TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the watchdog.
ADDR_W, 32, width of PADDR and requester address.
DATA_W, 32, width of PWDATA, PRDATA and requester data.

Ports:
_PCLK  in  1  APB clock, all logic on rising edge.
_PRESETn  in  1  reset, asynchronous assert, active-low.
req0_valid / req1_valid  in  1  request pending; held until the matching ready.
req0_write / req1_write  in  1  1 = write, 0 = read.
req0_addr / req1_addr  in  ADDR_W  target address.
req0_wdata / req1_wdata  in  DATA_W  write data.
req0_ready / req1_ready  out  1  combinational accept strobe; request is captured on this edge.
rsp0_valid / rsp1_valid  out  1  one-cycle completion pulse.
rsp0_rdata / rsp1_rdata  out  DATA_W  read data, valid with rsp; 0 for writes and errors.
rsp0_err / rsp1_err  out  1  slave PSLVERR or timeout, valid with rsp.
_PSEL1  out  1  slave select.
_PENABLE  out  1  access phase.
_PWRITE  out  1  direction.
_PADDR  out  ADDR_W  address.
_PWDATA  out  DATA_W  write data.
_PRDATA  in  DATA_W  slave read data.
_PREADY  in  1  slave ready.
_PSLVERR  in  1  slave error, sampled with PREADY.

Behaviour:
- Reset (async, _PRESETn=0): state IDLE. All outputs 0: PSEL1, PENABLE, PWRITE, PADDR, PWDATA, rsp*_valid/rdata/err. Priority pointer favours requester 0. Watchdog counter 0. Any in-flight transfer is dropped with no response.
- FSM states: IDLE, SETUP, ACCESS.
- Grant window: in IDLE, or in ACCESS on the completing cycle (PREADY=1 or timeout hit). If any reqN_valid is high in the window, the winner's reqN_ready=1 combinationally. On that edge, winner addr/wdata/write are latched into PADDR/PWDATA/PWRITE, and next state is SETUP. At most one ready per cycle; ready is never asserted outside the window.
- Arbitration: one valid wins outright. Both valid: winner is the requester not granted last. The pointer updates only on a grant.
- SETUP: PSEL1=1, PENABLE=0, exactly one cycle, then ACCESS.
- ACCESS: PSEL1=1, PENABLE=1. PADDR/PWDATA/PWRITE stay stable from SETUP until completion.
  - PREADY=0: stay in ACCESS; watchdog increments.
  - PREADY=1: transfer completes. Next state is SETUP on a new grant (back-to-back, PSEL1 stays 1, PENABLE drops to 0), else IDLE with PSEL1=0.
- Response: registered. rspN_valid pulses for one cycle, on the cycle after completion, to the owner of the completed transfer. rspN_err=PSLVERR. rspN_rdata=PRDATA if read and no error, else 0. The non-owner's rsp outputs stay 0.
- Watchdog (TIMEOUT>0): counter clears on entry to SETUP and counts ACCESS cycles with PREADY=0. When it reaches TIMEOUT, the transfer completes as an error: rsp err=1, rdata=0.
  - Next state follows the completion rule above: PSEL1/PENABLE drop to 0 unless a new grant in that window moves straight to SETUP.
  - Counter width is $clog2(TIMEOUT+1). If PREADY and timeout coincide, PREADY wins: normal completion.
- Minimum transfer: 2 cycles (SETUP plus one ACCESS). A new request can always be accepted in the completion cycle.

Decomposition:
- Package apb_pkg: state enum (IDLE=0, SETUP=1, ACCESS=2, 2-bit), default ADDR_W/DATA_W constants, requester-id type.
- Sub-module apb_rr_arb:
  - Inputs: 2 requests, enable.
  - Outputs: one-hot grant and grant index.
  - Holds the last-grant pointer.
  - Instantiated once.

Test Plan:
- Reset, then req0 write addr 3 data 0xA5A5_0001 with slave PREADY=1 immediately -> SETUP 1 cycle, ACCESS 1 cycle, rsp0_valid 1 cycle later, err=0. Then req0 read addr 3 -> rsp0_rdata=0xA5A5_0001.
- req0 and req1 valid on the same edge (addr 1 / addr 2) -> req0 granted first. req1 granted in req0's completion cycle with no IDLE gap. Repeat -> req1 now wins the tie.
- Slave inserts 3 wait states -> PENABLE high for 4 cycles, PADDR/PWDATA stable throughout, rsp after the 4th.
- TIMEOUT=4, slave never asserts PREADY -> after 4 ACCESS cycles transfer ends, PSEL1 drops, rsp err=1, rdata=0.
- Read of an unwritten address (slave PSLVERR=1 with PREADY) -> rsp err=1, rdata=0. Write to addr ≥32 -> rsp err=1.
- _PRESETn pulsed low mid-ACCESS -> PSEL1/PENABLE drop to 0 immediately, no rsp pulse, next request after release completes normally.
